// File: rtl/mult_pipe_unit.sv
// mult_pipe_unit: pipelined RV M-extension multiplier (mul/mulh/mulhsu/mulhu) with tagged in-order results
module mult_pipe_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [2:0]       mult_op,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [XLEN-1:0]  C,
  output logic [TAG_W-1:0] o_tag,
  output logic             mult_stall
);
  logic              stall, acc;
  logic [STAGES-1:0] v;
  logic [XLEN-1:0]   d [STAGES];
  logic [TAG_W-1:0]  t [STAGES];
  logic [XLEN:0]     a_ext, b_ext;
  logic [2*XLEN-1:0] pa, pb, p;
  logic [XLEN-1:0]   res;
  assign stall      = o_valid & ~o_ready;
  assign i_ready    = ~stall;
  assign mult_stall = i_valid & stall;
  assign acc        = i_valid & ~stall;
  assign o_valid    = v[STAGES-1];
  assign C          = d[STAGES-1];
  assign o_tag      = t[STAGES-1];
  // Only the low 2*XLEN product bits are ever selected, so the operands need only that width.
  always_comb begin
    a_ext = {(mult_op[1:0] == 2'b01 || mult_op[1:0] == 2'b10) & A[XLEN-1], A};
    b_ext = {(mult_op[1:0] == 2'b01) & B[XLEN-1], B};
    pa    = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
    pb    = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
    p     = pa * pb;
    res   = mult_op[2] ? '0 : (mult_op[1:0] == 2'b00 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
        t[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else if (!stall) begin
      v[0] <= acc;
      d[0] <= res;
      t[0] <= i_tag;
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
        t[i] <= t[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mult_pipe_unit.sv
// tb_mult_pipe_unit: table-driven and sequence checks of mult_pipe_unit with a result scoreboard
module tb_mult_pipe_unit;
  logic        clk = 0, rst = 1, flush = 0, i_valid = 0, o_ready = 1;
  logic        i_ready, o_valid, mult_stall;
  logic [2:0]  mult_op = 0;
  logic [31:0] A = 0, B = 0, C;
  logic [4:0]  i_tag = 0, o_tag;

  mult_pipe_unit #(.XLEN(32), .STAGES(3), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_ready(i_ready),
    .mult_op(mult_op), .A(A), .B(B), .i_tag(i_tag), .o_valid(o_valid),
    .o_ready(o_ready), .C(C), .o_tag(o_tag), .mult_stall(mult_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] c;
  } vec_t;

  typedef struct {
    logic [31:0] c;
    logic [4:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  vec_t        tbl[11];
  int          cyc = 0, checks = 0, fails = 0;
  bit          lat_chk = 0;
  logic [31:0] next_c = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  function automatic logic [31:0] gold(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax = (op[1:0] == 2'b01 || op[1:0] == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    logic [63:0] bx = (op[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    logic [63:0] p  = ax * bx;
    return op[2] ? 32'd0 : (op[1:0] == 2'b00 ? p[31:0] : p[63:32]);
  endfunction

  // One clock: score any output transfer, record any accepted op, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (o_valid && o_ready) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result actual C=%h tag=%0d required=none", C, o_tag);
      end else begin
        e = q.pop_front();
        chk("result_C", C, e.c);
        chk("result_tag", 32'(o_tag), 32'(e.tag));
        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
      end
    end
    if (i_valid && i_ready && !flush) q.push_back('{c: next_c, tag: i_tag, acc: cyc, lat: lat_chk});
    if (flush) q.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] c);
    mult_op = op; A = a; B = b; i_tag = tag; next_c = c;
  endtask

  task automatic send1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] c, input string n);
    drive(op, a, b, tag, c);
    o_ready = 1; i_valid = 1; lat_chk = 1;
    cycle();
    i_valid = 0; lat_chk = 0;
    repeat (5) cycle();
    chk({n, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 32'd7,        32'd6,        5'd3,  32'd42};
    tbl[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000};
    tbl[2]  = '{3'd0, 32'h80000000, 32'h80000000, 5'd5,  32'h00000000};
    tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF};
    tbl[4]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE};
    tbl[5]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000000};
    tbl[6]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        5'd9,  32'hFFFFFFFE};
    tbl[7]  = '{3'd4, 32'd7,        32'd6,        5'd10, 32'h00000000};
    tbl[8]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd11, 32'h3FFFFFFF};
    tbl[9]  = '{3'd2, 32'h80000000, 32'd2,        5'd12, 32'hFFFFFFFF};
    tbl[10] = '{3'd3, 32'h80000000, 32'd2,        5'd31, 32'h00000001};

    @(posedge clk);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_C", C, 32'd0);
    chk("rst_o_tag", 32'(o_tag), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    chk("rst_mult_stall", 32'(mult_stall), 32'd0);
    rst = 0;
    cycle();

    foreach (tbl[i]) send1(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].c, $sformatf("vec%0d", i));

    // Four back-to-back ops with the consumer stalling for two cycles mid-stream.
    begin
      int idx = 0;
      bit acc;
      for (int k = 0; k < 12; k++) begin
        i_valid = idx < 4;
        o_ready = !(k == 3 || k == 4);
        drive(3'd0, 32'(idx + 1), 32'd3, 5'(20 + idx), 32'((idx + 1) * 3));
        #1;
        acc = i_valid && i_ready;
        if (k == 3 || k == 4) begin
          chk("bp_i_ready", 32'(i_ready), 32'd0);
          chk("bp_mult_stall", 32'(mult_stall), 32'd1);
        end
        cycle();
        if (acc) idx++;
      end
      i_valid = 0; o_ready = 1;
      repeat (5) cycle();
      chk("bp_accepted", 32'(idx), 32'd4);
      chk("bp_drained", 32'(q.size()), 32'd0);
    end

    // Two ops in flight plus a same-cycle accept, all killed by a flush pulse.
    o_ready = 1;
    for (int k = 0; k < 2; k++) begin
      drive(3'd0, 32'd5, 32'(k + 1), 5'(k + 1), 32'(5 * (k + 1)));
      i_valid = 1;
      cycle();
    end
    drive(3'd0, 32'd9, 32'd9, 5'd3, 32'd81);
    flush = 1;
    cycle();
    flush = 0; i_valid = 0;
    chk("flush_i_ready", 32'(i_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("flush_no_valid", 32'(o_valid), 32'd0);
      cycle();
    end
    send1(3'd3, 32'h00010000, 32'h00010000, 5'd17, 32'h00000001, "post_flush");

    // Asynchronous reset with three ops in flight and a stalled result at the output.
    o_ready = 0; i_valid = 1;
    for (int k = 0; k < 3; k++) begin
      drive(3'd0, 32'd2, 32'(k + 1), 5'(k + 1), 32'(2 * (k + 1)));
      cycle();
    end
    i_valid = 0;
    #1;
    chk("pre_rst_o_valid", 32'(o_valid), 32'd1);
    rst = 1;
    #1;
    chk("async_rst_o_valid", 32'(o_valid), 32'd0);
    chk("async_rst_i_ready", 32'(i_ready), 32'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    o_ready = 1;
    repeat (2) cycle();
    chk("post_rst_idle", 32'(o_valid), 32'd0);
    send1(3'd0, 32'hFFFFFFFF, 32'd2, 5'd6, 32'hFFFFFFFE, "post_rst");

    // Random sweep with random handshake pressure against the 64-bit golden model.
    for (int k = 0; k < 200; k++) begin
      logic [2:0]  op = 3'($urandom_range(0, 7));
      logic [31:0] a  = (k % 7 == 0) ? 32'h80000000 : $urandom;
      logic [31:0] b  = (k % 5 == 0) ? 32'hFFFFFFFF : $urandom;
      drive(op, a, b, 5'($urandom), gold(op, a, b));
      i_valid = ($urandom % 4) != 0;
      o_ready = ($urandom % 4) != 0;
      cycle();
    end
    i_valid = 0; o_ready = 1;
    repeat (6) cycle();
    chk("random_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
